// File: rtl/press_pkg.sv
// Shared types and helpers for the push-button gesture classifier.
// The mode controller reuses pulse_t to name the gesture it was given.
package press_pkg;

  // Classifier FSM states.
  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HELD,
    GAP,
    PRESS2
  } state_t;

  // Gesture kinds; at most one is signalled per cycle.
  typedef enum logic [1:0] {
    PULSE_NONE,
    PULSE_SHORT,
    PULSE_LONG,
    PULSE_DOUBLE
  } pulse_t;

  // Convert a duration in milliseconds to clock cycles.
  function automatic int ms_to_cycles(input int clk_freq_hz, input int ms);
    return clk_freq_hz / 1000 * ms;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_filter.sv
// Two-flop synchroniser plus debounce counter for the raw key.
// key_level only changes after key_sync has disagreed with it for
// DB_CYCLES consecutive cycles; key_press / key_release are registered
// edge strobes of key_level, one cycle after the level change.
module key_filter #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Debounce: count disagreement cycles, toggle the level on the last one.
  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    cnt_d       = '0;
    level_d     = level_q;
    level_dly_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d   = level_q & ~level_dly_q;
    release_d = ~level_q & level_dly_q;
  end

  // Synchroniser, debounce state and edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short, long and double
// presses, emitting one registered single-cycle pulse per gesture.
module press_classifier
  import press_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_MS       = 1000,
  parameter int DOUBLE_GAP_MS = 300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic busy
);

  localparam int DB_CYCLES   = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int LONG_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
  localparam int GAP_CYCLES  = ms_to_cycles(CLK_FREQ_HZ, DOUBLE_GAP_MS);
  localparam int TW          = $clog2(max_int(LONG_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  if (DB_CYCLES < 1 || LONG_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_params
    $error("press_classifier: derived cycle counts must all be >= 1");
  end

  logic key_press;
  logic key_release;

  key_filter #(
    .DB_CYCLES (DB_CYCLES)
  ) u_key_filter (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   timer_inc;
  pulse_t          pulse;
  logic            short_q, long_q, double_q, busy_q;

  // Next-state, timer and gesture decision. Within PRESS1/PRESS2 a release
  // beats the long timeout; within GAP a press beats the gap timeout.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pulse     = PULSE_NONE;
    timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (key_press) begin
          state_d = PRESS1;
          timer_d = '0;
        end
      end
      PRESS1: begin
        if (key_release) begin
          state_d = GAP;
          timer_d = '0;
        end else if (timer_q == LONG_LAST) begin
          pulse   = PULSE_LONG;
          state_d = LONG_HELD;
        end else begin
          timer_d = timer_inc;
        end
      end
      LONG_HELD: begin
        if (key_release) state_d = IDLE;
      end
      GAP: begin
        if (key_press) begin
          state_d = PRESS2;
          timer_d = '0;
        end else if (timer_q == GAP_LAST) begin
          pulse   = PULSE_SHORT;
          state_d = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      PRESS2: begin
        if (key_release) begin
          pulse   = PULSE_DOUBLE;
          state_d = IDLE;
        end else if (timer_q == LONG_LAST) begin
          pulse   = PULSE_LONG;
          state_d = LONG_HELD;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      short_q  <= (pulse == PULSE_SHORT);
      long_q   <= (pulse == PULSE_LONG);
      double_q <= (pulse == PULSE_DOUBLE);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign double_pulse = double_q;
  assign busy         = busy_q;

endmodule
